// File: rtl/qspi_arb_pkg.sv
// qspi_arb_pkg: shared state encoding, port indices and read-tag type for the
// QSPI / local-writer RAM arbiter.
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic PORT_HOST  = 1'b0;
  localparam logic PORT_LOCAL = 1'b1;

  localparam int WAIT_W = 8;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/qspi_arb_rd_pipe.sv
// qspi_arb_rd_pipe: read-tag shift register matched to the registered command
// stage plus RAM latency, and the read-data demux back to the issuing port.
module qspi_arb_rd_pipe
  import qspi_arb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int RAM_RD_LAT = 1
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_push,
  input  logic              I_port,
  input  logic [DATA_W-1:0] I_ram_rdata,
  output logic              O_rvalid0,
  output logic              O_rvalid1,
  output logic [DATA_W-1:0] O_rdata0,
  output logic [DATA_W-1:0] O_rdata1
);

  localparam int DEPTH = RAM_RD_LAT + 1;

  rd_tag_t [DEPTH-1:0] pipe_r;
  rd_tag_t             push_tag_s;
  rd_tag_t             head_s;

  // Build the tag for the beat accepted this cycle.
  always_comb begin
    push_tag_s.valid = I_push;
    push_tag_s.port  = I_port;
  end

  // Tag shift register; reset drops every in-flight read.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pipe_r <= {DEPTH{2'b00}};
    end else begin
      pipe_r <= {pipe_r[DEPTH-2:0], push_tag_s};
    end
  end

  assign head_s = pipe_r[DEPTH-1];

  // Route returning RAM data to the port that issued the read.
  always_comb begin
    O_rvalid0 = 1'b0;
    O_rvalid1 = 1'b0;
    O_rdata0  = {DATA_W{1'b0}};
    O_rdata1  = {DATA_W{1'b0}};
    if (head_s.valid && (head_s.port == PORT_HOST)) begin
      O_rvalid0 = 1'b1;
      O_rdata0  = I_ram_rdata;
    end else if (head_s.valid) begin
      O_rvalid1 = 1'b1;
      O_rdata1  = I_ram_rdata;
    end else begin
      O_rvalid0 = 1'b0;
      O_rvalid1 = 1'b0;
    end
  end

endmodule

// File: rtl/qspi_ram_arbiter.sv
// qspi_ram_arbiter: shares one single-port RAM between the QSPI host (port 0)
// and the local frame writer (port 1). Optional stats outputs: QSPI_ARB_STATS_EN.
module qspi_ram_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 8,
  parameter int RAM_RD_LAT = 1,
  parameter int MAX_WAIT   = 16
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_req0,
  input  logic              I_req1,
  input  logic              I_we0,
  input  logic              I_we1,
  input  logic              I_lock0,
  input  logic              I_lock1,
  input  logic [ADDR_W-1:0] I_addr0,
  input  logic [ADDR_W-1:0] I_addr1,
  input  logic [DATA_W-1:0] I_wdata0,
  input  logic [DATA_W-1:0] I_wdata1,
  output logic              O_gnt0,
  output logic              O_gnt1,
  output logic              O_rvalid0,
  output logic              O_rvalid1,
  output logic [DATA_W-1:0] O_rdata0,
  output logic [DATA_W-1:0] O_rdata1,
  output logic              O_ram_en,
  output logic              O_ram_we,
  output logic [ADDR_W-1:0] O_ram_addr,
  output logic [DATA_W-1:0] O_ram_wdata,
  input  logic [DATA_W-1:0] I_ram_rdata
`ifdef QSPI_ARB_STATS_EN
  ,
  output logic [31:0]       O_gnt_cnt0,
  output logic [31:0]       O_gnt_cnt1,
  output logic [15:0]       O_force_cnt
`endif
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  arb_state_e        state_r, state_s;
  logic [WAIT_W-1:0] wait0_r, wait1_r;
  logic              aged0_s, aged1_s;
  logic              gnt0_s, gnt1_s;
  logic              rd_push_s, rd_port_s;

  // A port is aged only while it is still asking.
  assign aged0_s = I_req0 && (wait0_r == MAX_WAIT_C);
  assign aged1_s = I_req1 && (wait1_r == MAX_WAIT_C);

  // Grant selection and next-state decision.
  always_comb begin
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (I_req0 && !aged1_s) begin
          gnt0_s = 1'b1;
        end else if (I_req1) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
        if (gnt0_s && I_lock0) begin
          state_s = OWN0;
        end else if (gnt1_s && I_lock1) begin
          state_s = OWN1;
        end else begin
          state_s = IDLE;
        end
      end
      OWN0: begin
        gnt0_s = I_req0;
        // Release, end of burst, or the other port aged out: beat still granted.
        if (!I_req0 || !I_lock0 || aged1_s) begin
          state_s = IDLE;
        end else begin
          state_s = OWN0;
        end
      end
      OWN1: begin
        gnt1_s = I_req1;
        if (!I_req1 || !I_lock1 || aged0_s) begin
          state_s = IDLE;
        end else begin
          state_s = OWN1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Grants are forced low while reset is asserted.
  assign O_gnt0 = gnt0_s & I_rst_n;
  assign O_gnt1 = gnt1_s & I_rst_n;

  // Arbitration state register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Per-port wait counters: count denied cycles, saturate at MAX_WAIT.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wait0_r <= {WAIT_W{1'b0}};
      wait1_r <= {WAIT_W{1'b0}};
    end else begin
      if (!I_req0 || gnt0_s) begin
        wait0_r <= {WAIT_W{1'b0}};
      end else if (wait0_r != MAX_WAIT_C) begin
        wait0_r <= wait0_r + 8'd1;
      end else begin
        wait0_r <= wait0_r;
      end
      if (!I_req1 || gnt1_s) begin
        wait1_r <= {WAIT_W{1'b0}};
      end else if (wait1_r != MAX_WAIT_C) begin
        wait1_r <= wait1_r + 8'd1;
      end else begin
        wait1_r <= wait1_r;
      end
    end
  end

  // Registered RAM command, one cycle per accepted beat.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_ram_en    <= 1'b0;
      O_ram_we    <= 1'b0;
      O_ram_addr  <= {ADDR_W{1'b0}};
      O_ram_wdata <= {DATA_W{1'b0}};
    end else if (gnt0_s) begin
      O_ram_en    <= 1'b1;
      O_ram_we    <= I_we0;
      O_ram_addr  <= I_addr0;
      O_ram_wdata <= I_wdata0;
    end else if (gnt1_s) begin
      O_ram_en    <= 1'b1;
      O_ram_we    <= I_we1;
      O_ram_addr  <= I_addr1;
      O_ram_wdata <= I_wdata1;
    end else begin
      O_ram_en    <= 1'b0;
      O_ram_we    <= 1'b0;
      O_ram_addr  <= {ADDR_W{1'b0}};
      O_ram_wdata <= {DATA_W{1'b0}};
    end
  end

  assign rd_push_s = (gnt0_s && !I_we0) || (gnt1_s && !I_we1);
  assign rd_port_s = gnt1_s ? PORT_LOCAL : PORT_HOST;

  qspi_arb_rd_pipe #(
    .DATA_W     (DATA_W),
    .RAM_RD_LAT (RAM_RD_LAT)
  ) u_rd_pipe (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_push      (rd_push_s),
    .I_port      (rd_port_s),
    .I_ram_rdata (I_ram_rdata),
    .O_rvalid0   (O_rvalid0),
    .O_rvalid1   (O_rvalid1),
    .O_rdata0    (O_rdata0),
    .O_rdata1    (O_rdata1)
  );

`ifdef QSPI_ARB_STATS_EN
  logic [31:0] gnt_cnt0_r, gnt_cnt1_r;
  logic [15:0] force_cnt_r;
  logic        force_s;

  // A forced break is a locked beat cut short because the other port aged out.
  assign force_s = ((state_r == OWN0) && I_req0 && I_lock0 && aged1_s) ||
                   ((state_r == OWN1) && I_req1 && I_lock1 && aged0_s);

  // Accepted-beat and forced-break counters, wrapping on overflow.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      gnt_cnt0_r  <= 32'd0;
      gnt_cnt1_r  <= 32'd0;
      force_cnt_r <= 16'd0;
    end else begin
      gnt_cnt0_r  <= gnt0_s  ? gnt_cnt0_r + 32'd1  : gnt_cnt0_r;
      gnt_cnt1_r  <= gnt1_s  ? gnt_cnt1_r + 32'd1  : gnt_cnt1_r;
      force_cnt_r <= force_s ? force_cnt_r + 16'd1 : force_cnt_r;
    end
  end

  assign O_gnt_cnt0  = gnt_cnt0_r;
  assign O_gnt_cnt1  = gnt_cnt1_r;
  assign O_force_cnt = force_cnt_r;
`endif

endmodule
